// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM receiver: collects framed serial slots into parallel A..D outputs
module tdm_demux4 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    input  logic             V,
    input  logic             SOF,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [1:0]       S,
    output logic             F,
    output logic             ERR
);

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_sh2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_d;
    logic [1:0]       r_s;
    logic             r_f;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_s     <= 2'd0;
            r_f     <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_f   <= 1'b0;
            r_err <= 1'b0;
            if (V) begin
                case (r_state)
                    ST_IDLE: begin
                        // Beats without SOF while idle are silently dropped.
                        if (SOF) begin
                            r_sh0   <= I;
                            r_s     <= 2'd1;
                            r_state <= ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (SOF) begin
                            // Early SOF: abandon the partial frame and restart at slot 1.
                            r_err <= 1'b1;
                            r_sh0 <= I;
                            r_s   <= 2'd1;
                        end else begin
                            case (r_s)
                                2'd1: begin
                                    r_sh1 <= I;
                                    r_s   <= 2'd2;
                                end
                                2'd2: begin
                                    r_sh2 <= I;
                                    r_s   <= 2'd3;
                                end
                                2'd3: begin
                                    r_a     <= r_sh0;
                                    r_b     <= r_sh1;
                                    r_c     <= r_sh2;
                                    r_d     <= I;
                                    r_f     <= 1'b1;
                                    r_s     <= 2'd0;
                                    r_state <= ST_IDLE;
                                end
                                default: begin
                                    r_s     <= 2'd0;
                                    r_state <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                    default: begin
                        r_s     <= 2'd0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign A   = r_a;
    assign B   = r_b;
    assign C   = r_c;
    assign D   = r_d;
    assign S   = r_s;
    assign F   = r_f;
    assign ERR = r_err;

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of a 4-slot time-division link whose transmit end is the 4:1 mux (mux4_1).
- Accepts one WIDTH-bit word per valid beat, framed by a start-of-frame marker on slot 0.
- Collects four consecutive slots and presents them in parallel on A/B/C/D, updated atomically once per complete frame.
- Sits directly after the serial slot channel; downstream logic samples A..D when F pulses.

Parameters:
- WIDTH, 2, bit width of each slot word and of each parallel output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- I  input  WIDTH  serial slot data.
- V  input  1  I is valid this cycle (one beat per cycle when high).
- SOF  input  1  start of frame; qualified by V; marks I as slot 0.
- A  output  WIDTH  slot 0 of last complete frame (registered).
- B  output  WIDTH  slot 1 of last complete frame (registered).
- C  output  WIDTH  slot 2 of last complete frame (registered).
- D  output  WIDTH  slot 3 of last complete frame (registered).
- S  output  2  index of next expected slot (registered).
- F  output  1  one-cycle pulse: A..D just updated with a new frame.
- ERR  output  1  one-cycle pulse: frame aborted by an early SOF.

Behaviour:
- Reset (rst=1 at a clock edge): A=B=C=D=0, S=0, F=0, ERR=0, internal slot shadows 0 (slot 0..2 registers), state IDLE. rst has priority over all inputs. Reset mid-frame discards the partial frame; A..D are cleared.
- Beat = cycle with V=1. Cycles with V=0 change nothing except F/ERR returning to 0. No timeout; a frame may stall indefinitely.
- FSM states: IDLE (awaiting SOF), COLLECT (slots 1..3 outstanding).
- IDLE:
  - V=1 & SOF=1: shadow0<=I, S<=1, go COLLECT.
  - V=1 & SOF=0: beat discarded, S stays 0, no ERR.
- COLLECT, V=1 & SOF=0:
  - S=1: shadow1<=I, S<=2.
  - S=2: shadow2<=I, S<=3.
  - S=3: A<=shadow0, B<=shadow1, C<=shadow2, D<=I simultaneously; F<=1 for exactly one cycle; S<=0; go IDLE.
- COLLECT, V=1 & SOF=1 (early SOF): ERR<=1 for one cycle; partial frame dropped (A..D unchanged, no F); shadow0<=I, S<=1, stay in COLLECT.
- Latency: A..D and F become visible the cycle after the slot-3 beat edge.
- Back-to-back frames at full rate: SOF beat on the cycle immediately after a slot-3 beat is accepted normally. F of the previous frame and capture of the new slot 0 occur together.
- A..D never change except on a completed frame or reset; no partial updates.
- F and ERR never asserted in the same cycle.
- S wraps 3->0 only through frame completion; S is never observed as 0 while in COLLECT.
- Inputs are sampled only at clock edges; I/SOF ignored when V=0.

Test Plan:
- Reset: hold rst=1 two cycles with V=1, SOF=1, I=11 -> A..D=00, S=0, F=0, ERR=0.
- Nominal frame: beats 01(SOF), 10, 11, 00 on consecutive cycles -> one cycle after the 4th beat, A=01 B=10 C=11 D=00, F=1 for one cycle; S sequence 1,2,3,0.
- Stalls and ignored data: same frame with V=0 gaps of 1-3 cycles between beats (I toggling during gaps), plus two V=1 SOF=0 beats before the first SOF -> identical result to the nominal frame, single F pulse, ERR never 1.
- Early SOF: 01(SOF), 10, then 11(SOF), 10, 01, 00 -> ERR pulse after the third beat, A..D unchanged then; final A=11 B=10 C=01 D=00 with one F.
- Back-to-back frames: frame 01,10,11,00 immediately followed by 11(SOF),11,11,11 -> F pulses twice, 4 cycles apart; A..D=01,10,11,00 then all 11.
- Reset mid-frame: 01(SOF), 10, then rst=1 one cycle, then nominal frame 00(SOF),01,10,11 -> A..D=0 after reset, then A=00 B=01 C=10 D=11; no ERR.
